// File: rtl/ext_pkg.sv
// ext_pkg: extension mode encodings shared by the extension unit and its core.
package ext_pkg;
    localparam int MODE_W = 3;
    localparam logic [MODE_W-1:0] EXT_SIGN     = 3'd0;
    localparam logic [MODE_W-1:0] EXT_ZERO     = 3'd1;
    localparam logic [MODE_W-1:0] EXT_HIGH     = 3'd2;
    localparam logic [MODE_W-1:0] EXT_SIGN_SHL = 3'd3;
    localparam logic [MODE_W-1:0] EXT_LB       = 3'd4;
    localparam logic [MODE_W-1:0] EXT_LBU      = 3'd5;
    localparam logic [MODE_W-1:0] EXT_LH       = 3'd6;
    localparam logic [MODE_W-1:0] EXT_LHU      = 3'd7;
endpackage

// File: rtl/ext_core.sv
// ext_core: combinational immediate extension and sub-word load extraction.
module ext_core
    import ext_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16,
    parameter int SHL_N  = 2,
    parameter int OFF_W  = $clog2(DATA_W/8)
) (
    input  logic [MODE_W-1:0] mode,
    input  logic [DATA_W-1:0] word,
    input  logic [OFF_W-1:0]  off,
    output logic [DATA_W-1:0] data,
    output logic              err
);
    localparam logic [OFF_W-1:0] MAX_H = OFF_W'(DATA_W/8-2);
    logic [IMM_W-1:0]  imm;
    logic [DATA_W-1:0] sext;
    logic [DATA_W-1:0] sh;
    logic [7:0]        b;
    logic [15:0]       h;
    logic              h_bad;
    assign imm   = word[IMM_W-1:0];
    assign sext  = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
    assign sh    = word >> {off, 3'b000};
    assign b     = sh[7:0];
    assign h     = sh[15:0];
    // a halfword must be even-aligned and lie fully inside the word
    assign h_bad = off[0] | (off > MAX_H);
    always_comb begin
        data = '0;
        err  = 1'b0;
        case (mode)
            EXT_SIGN:     data = sext;
            EXT_ZERO:     data = {{(DATA_W-IMM_W){1'b0}}, imm};
            EXT_HIGH:     data = {imm, {(DATA_W-IMM_W){1'b0}}};
            EXT_SIGN_SHL: data = sext << SHL_N;
            EXT_LB,
            EXT_LBU:      data = {{(DATA_W-8){~mode[0] & b[7]}}, b};
            default: begin
                err  = h_bad;
                data = h_bad ? '0 : {{(DATA_W-16){~mode[0] & h[15]}}, h};
            end
        endcase
    end
endmodule

// File: rtl/ext_unit.sv
// ext_unit: extension core behind a registered valid/ready output with a one-entry skid.
module ext_unit
    import ext_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16,
    parameter int SHL_N  = 2,
    parameter int OFF_W  = $clog2(DATA_W/8)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_mode,
    input  logic [DATA_W-1:0] in_word,
    input  logic [OFF_W-1:0]  in_off,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_err,
    output logic [1:0]        occupancy
);
    logic [DATA_W-1:0] new_data, out_data_d, out_data_q, skid_data_d, skid_data_q;
    logic              new_err, out_err_d, out_err_q, skid_err_d, skid_err_q;
    logic              out_valid_d, out_valid_q, skid_valid_d, skid_valid_q;
    logic              push, pop;

    ext_core #(.DATA_W(DATA_W), .IMM_W(IMM_W), .SHL_N(SHL_N), .OFF_W(OFF_W)) u_core (
        .mode (in_mode),
        .word (in_word),
        .off  (in_off),
        .data (new_data),
        .err  (new_err)
    );

    assign in_ready  = ~skid_valid_q & ~flush & ~reset;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid_q & out_ready;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_err   = out_err_q;
    assign occupancy = {1'b0, out_valid_q} + {1'b0, skid_valid_q};

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_err_d    = out_err_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_err_d   = skid_err_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (skid_valid_q & pop) begin
            out_data_d   = skid_data_q;
            out_err_d    = skid_err_q;
            skid_valid_d = 1'b0;
        end else if (push & (~out_valid_q | pop)) begin
            out_data_d  = new_data;
            out_err_d   = new_err;
            out_valid_d = 1'b1;
        end else if (push) begin
            skid_data_d  = new_data;
            skid_err_d   = new_err;
            skid_valid_d = 1'b1;
        end else if (pop) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_err_q    <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_err_q   <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_err_q    <= out_err_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_err_q   <= skid_err_d;
        end
    end
endmodule

// File: tb/tb_ext_unit.sv
// tb_ext_unit: directed vectors with hand-computed results for ext_unit.
module tb_ext_unit;
    import ext_pkg::*;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_mode = 3'd0;
    logic [31:0] in_word = 32'd0;
    logic [1:0]  in_off = 2'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic        out_err;
    logic [1:0]  occupancy;
    int          total = 0;
    int          bad = 0;

    ext_unit dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_word   (in_word),
        .in_off    (in_off),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] m, input logic [31:0] w, input logic [1:0] o);
        in_valid = 1'b1;
        in_mode  = m;
        in_word  = w;
        in_off   = o;
    endtask

    task automatic one(input string tag, input logic [2:0] m, input logic [31:0] w,
                       input logic [1:0] o, input logic [31:0] ed, input logic ee);
        drive(m, w, o);
        tick();
        in_valid = 1'b0;
        check({tag, "_v"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_d"}, out_data, ed);
        check({tag, "_e"}, {31'd0, out_err}, {31'd0, ee});
    endtask

    initial begin
        #12;
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_occ", {30'd0, occupancy}, 32'd0);
        check("rst_ready", {31'd0, in_ready}, 32'd0);
        check("rst_data", out_data, 32'd0);
        reset = 1'b0;
        #1;
        check("rel_ready", {31'd0, in_ready}, 32'd1);

        one("sign", EXT_SIGN, 32'h0000_8001, 2'd0, 32'hFFFF_8001, 1'b0);
        one("zero", EXT_ZERO, 32'h0000_8001, 2'd0, 32'h0000_8001, 1'b0);
        one("high", EXT_HIGH, 32'h0000_1234, 2'd0, 32'h1234_0000, 1'b0);
        one("shl_neg", EXT_SIGN_SHL, 32'h0000_8000, 2'd0, 32'hFFFE_0000, 1'b0);
        one("shl_pos", EXT_SIGN_SHL, 32'h0000_7FFF, 2'd0, 32'h0001_FFFC, 1'b0);
        one("lb3", EXT_LB, 32'h80FF_7F01, 2'd3, 32'hFFFF_FF80, 1'b0);
        one("lbu2", EXT_LBU, 32'h80FF_7F01, 2'd2, 32'h0000_00FF, 1'b0);
        one("lb0", EXT_LB, 32'h80FF_7F01, 2'd0, 32'h0000_0001, 1'b0);
        one("lbu1", EXT_LBU, 32'h80FF_7F01, 2'd1, 32'h0000_007F, 1'b0);
        one("lh2", EXT_LH, 32'h80FF_7F01, 2'd2, 32'hFFFF_80FF, 1'b0);
        one("lhu0", EXT_LHU, 32'h80FF_7F01, 2'd0, 32'h0000_7F01, 1'b0);
        one("lhu2", EXT_LHU, 32'h80FF_7F01, 2'd2, 32'h0000_80FF, 1'b0);
        one("lh1", EXT_LH, 32'h80FF_7F01, 2'd1, 32'h0000_0000, 1'b1);
        one("lhu3", EXT_LHU, 32'h80FF_7F01, 2'd3, 32'h0000_0000, 1'b1);
        tick();
        check("idle_valid", {31'd0, out_valid}, 32'd0);

        // backpressure: A held in output, B parked in skid
        out_ready = 1'b0;
        drive(EXT_SIGN, 32'h0000_0001, 2'd0);
        tick();
        drive(EXT_ZERO, 32'h0000_FFFF, 2'd0);
        tick();
        in_valid = 1'b0;
        check("bp_occ", {30'd0, occupancy}, 32'd2);
        check("bp_ready", {31'd0, in_ready}, 32'd0);
        check("bp_a", out_data, 32'h0000_0001);
        tick();
        check("bp_hold", out_data, 32'h0000_0001);
        check("bp_hold_v", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b1;
        tick();
        check("bp_b", out_data, 32'h0000_FFFF);
        check("bp_b_v", {31'd0, out_valid}, 32'd1);
        check("bp_occ1", {30'd0, occupancy}, 32'd1);
        check("bp_ready1", {31'd0, in_ready}, 32'd1);
        tick();
        check("bp_empty", {31'd0, out_valid}, 32'd0);

        for (int i = 0; i < 20; i++) begin
            drive(EXT_ZERO, 32'(i + 100), 2'd0);
            tick();
            check("st_v", {31'd0, out_valid}, 32'd1);
            check("st_d", out_data, 32'(i + 100));
            check("st_occ", {30'd0, occupancy}, 32'd1);
        end
        in_valid = 1'b0;
        tick();
        check("st_end", {31'd0, out_valid}, 32'd0);

        out_ready = 1'b0;
        drive(EXT_ZERO, 32'h0000_0011, 2'd0);
        tick();
        drive(EXT_ZERO, 32'h0000_0022, 2'd0);
        tick();
        check("fl_occ2", {30'd0, occupancy}, 32'd2);
        flush = 1'b1;
        drive(EXT_ZERO, 32'h0000_0033, 2'd0);
        #1;
        check("fl_ready", {31'd0, in_ready}, 32'd0);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        check("fl_occ", {30'd0, occupancy}, 32'd0);
        check("fl_valid", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b1;
        tick();
        tick();
        check("fl_absent", {31'd0, out_valid}, 32'd0);

        out_ready = 1'b0;
        drive(EXT_ZERO, 32'h0000_0044, 2'd0);
        tick();
        drive(EXT_ZERO, 32'h0000_0055, 2'd0);
        tick();
        in_valid = 1'b0;
        check("ar_occ2", {30'd0, occupancy}, 32'd2);
        #2;
        reset = 1'b1;
        #1;
        check("ar_valid", {31'd0, out_valid}, 32'd0);
        check("ar_occ", {30'd0, occupancy}, 32'd0);
        check("ar_ready", {31'd0, in_ready}, 32'd0);
        check("ar_data", out_data, 32'd0);
        reset = 1'b0;
        #1;
        out_ready = 1'b1;
        one("ar_first", EXT_SIGN, 32'h0000_FFFF, 2'd0, 32'hFFFF_FFFF, 1'b0);
        tick();
        check("ar_drain", {31'd0, out_valid}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
